gbprocessor_gen: RTL and testbench

- Parametrised successor of the 8-bit accumulator core. Generalised datapath width DATA_W.
- Register-to-register loads and two-byte immediate instructions, sequenced by a small fetch/operand FSM.
- Sits between the instruction-stream driver and the probe-based scoreboard.
- All architectural state is exposed on probe every cycle.

---
 rtl/gbproc_pkg.sv | 51 +++++
 rtl/gbprocessor_gen_alu.sv | 57 +++++
 rtl/gbprocessor_gen.sv | 130 +++++++++++++
 tb/tb_gbprocessor_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gbproc_pkg.sv
// Shared types and encodings for the parametrised accumulator core.
// Register index encoding, flag nibble layout and opcode class fields.
package gbproc_pkg;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_ADC,
      ALU_SUB,
      ALU_SBC,
      ALU_AND,
      ALU_XOR,
      ALU_OR,
      ALU_CP
   } alu_op_e;

   typedef enum logic {
      FETCH,
      OPERAND
   } state_e;

   localparam logic [2:0] REG_B    = 3'd0;
   localparam logic [2:0] REG_C    = 3'd1;
   localparam logic [2:0] REG_D    = 3'd2;
   localparam logic [2:0] REG_E    = 3'd3;
   localparam logic [2:0] REG_H    = 3'd4;
   localparam logic [2:0] REG_L    = 3'd5;
   localparam logic [2:0] REG_NONE = 3'd6;
   localparam logic [2:0] REG_A    = 3'd7;
   // Index 6 never names a register, so its storage slot holds F.
   localparam logic [2:0] REG_F_SLOT = 3'd6;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_H = 1;
   localparam int FLAG_C = 0;

   localparam logic [1:0] CLS_LD_IMM  = 2'b00;
   localparam logic [1:0] CLS_LD_REG  = 2'b01;
   localparam logic [1:0] CLS_ALU_REG = 2'b10;
   localparam logic [1:0] CLS_ALU_IMM = 2'b11;
   localparam logic [2:0] SRC_IMM     = 3'b110;

   function automatic logic is_two_beat(input logic [7:0] op);
      return (op[7:6] == CLS_LD_IMM || op[7:6] == CLS_ALU_IMM) && op[2:0] == SRC_IMM;
   endfunction

   function automatic int reset_value(input int idx);
      return (idx < 6) ? idx + 1 : 0;
   endfunction

endpackage

// File: rtl/gbprocessor_gen_alu.sv
// Combinational ALU for the accumulator core; flags are a {Z,N,H,C} nibble.
// H and C are carry/borrow out of bit 3 and bit DATA_W-1 respectively.
module gbalu_param
   import gbproc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        flags_in,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags_out
);

   alu_op_e           op_e;
   logic              carry_in;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [4:0]        half_sum;
   logic [4:0]        half_diff;
   logic              unused_flags;

   assign op_e         = alu_op_e'(op);
   assign unused_flags = ^flags_in[3:1];

   always_comb begin
      carry_in  = (op_e == ALU_ADC || op_e == ALU_SBC) ? flags_in[FLAG_C] : 1'b0;
      sum       = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, carry_in};
      diff      = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, carry_in};
      half_sum  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, carry_in};
      half_diff = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, carry_in};
      result    = '0;
      flags_out = '0;
      case (op_e)
         ALU_ADD, ALU_ADC: begin
            result            = sum[DATA_W-1:0];
            flags_out[FLAG_H] = half_sum[4];
            flags_out[FLAG_C] = sum[DATA_W];
         end
         ALU_SUB, ALU_SBC, ALU_CP: begin
            result            = diff[DATA_W-1:0];
            flags_out[FLAG_N] = 1'b1;
            flags_out[FLAG_H] = half_diff[4];
            flags_out[FLAG_C] = diff[DATA_W];
         end
         ALU_AND: begin
            result            = a & b;
            flags_out[FLAG_H] = 1'b1;
         end
         ALU_XOR: result = a ^ b;
         ALU_OR:  result = a | b;
      endcase
      flags_out[FLAG_Z] = (result == '0);
   end

endmodule

// File: rtl/gbprocessor_gen.sv
// Parametrised accumulator core with a FETCH/OPERAND sequencer for two-beat immediates.
// Optional INC/DEC opcodes are enabled by defining GBP_INC_DEC_EN.
module gbprocessor_gen
   import gbproc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            instruction,
   input  logic [DATA_W-1:0]     data,
   input  logic                  valid,
   output logic                  busy,
   output logic                  retire,
   output logic [8*DATA_W-1:0]   probe
);

   state_e            state, state_next;
   logic [7:0]        pending_op;
   logic [7:0]        cur_op;
   logic [DATA_W-1:0] regs [0:7];
   logic              execute, two_beat_start;
   logic [DATA_W-1:0] src_val, alu_a, alu_b, alu_result, wr_val, flags_full;
   logic [2:0]        alu_op, wr_dest;
   logic [3:0]        alu_flags, old_flags, new_flags;
   logic              inc_dec, wr_reg, wr_flags;

   assign cur_op         = (state == OPERAND) ? pending_op : instruction;
   assign two_beat_start = (state == FETCH) && valid && is_two_beat(instruction);
   assign execute        = valid && !two_beat_start;
   assign old_flags      = regs[REG_F_SLOT][DATA_W-1 -: 4];
   assign src_val        = (state == OPERAND) ? data :
                           (cur_op[2:0] == REG_NONE) ? '0 : regs[cur_op[2:0]];

   always_ff @(posedge clock) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH:   if (two_beat_start) state_next = OPERAND;
         OPERAND: if (valid)          state_next = FETCH;
      endcase
   end

   always_comb begin
      busy = (state == OPERAND);
   end

   // INC/DEC reuse the ALU as ADD/SUB of 1 on the destination register.
   always_comb begin
      inc_dec = 1'b0;
      alu_a   = regs[REG_A];
      alu_b   = src_val;
      alu_op  = cur_op[5:3];
`ifdef GBP_INC_DEC_EN
      if (cur_op[7:6] == CLS_LD_IMM && cur_op[2:1] == 2'b10 && cur_op[5:3] != REG_NONE) begin
         inc_dec = 1'b1;
         alu_a   = regs[cur_op[5:3]];
         alu_b   = DATA_W'(1);
         alu_op  = cur_op[0] ? ALU_SUB : ALU_ADD;
      end
`else
      inc_dec = 1'b0;
`endif
   end

   gbalu_param #(.DATA_W(DATA_W)) u_alu (
      .a         (alu_a),
      .b         (alu_b),
      .flags_in  (old_flags),
      .op        (alu_op),
      .result    (alu_result),
      .flags_out (alu_flags)
   );

   always_comb begin
      wr_reg   = 1'b0;
      wr_flags = 1'b0;
      wr_dest  = cur_op[5:3];
      wr_val   = src_val;
      if (execute) begin
         case (cur_op[7:6])
            CLS_LD_REG: wr_reg = 1'b1;
            CLS_LD_IMM: begin
               if (cur_op[2:0] == SRC_IMM) begin
                  wr_reg = 1'b1;
               end else if (inc_dec) begin
                  wr_reg   = 1'b1;
                  wr_flags = 1'b1;
                  wr_val   = alu_result;
               end
            end
            default: begin
               if (cur_op[7:6] == CLS_ALU_REG || cur_op[2:0] == SRC_IMM) begin
                  wr_flags = 1'b1;
                  wr_dest  = REG_A;
                  wr_val   = alu_result;
                  wr_reg   = (alu_op_e'(cur_op[5:3]) != ALU_CP);
               end
            end
         endcase
      end
   end

   always_comb begin
      new_flags              = {alu_flags[3:1], inc_dec ? old_flags[FLAG_C] : alu_flags[FLAG_C]};
      flags_full             = '0;
      flags_full[DATA_W-1 -: 4] = new_flags;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= DATA_W'(reset_value(i));
         pending_op <= '0;
         retire     <= 1'b0;
      end else begin
         retire <= execute;
         if (two_beat_start)                 pending_op    <= instruction;
         if (wr_reg && wr_dest != REG_NONE)  regs[wr_dest] <= wr_val;
         if (wr_flags)                       regs[REG_F_SLOT] <= flags_full;
      end
   end

   assign probe = {regs[REG_A], regs[REG_B], regs[REG_C], regs[REG_D],
                   regs[REG_E], regs[REG_F_SLOT], regs[REG_H], regs[REG_L]};

endmodule

// File: tb/tb_gbprocessor_gen.sv
// Self-checking bench for gbprocessor_gen: directed plan steps then a randomized
// instruction stream against an arithmetic reference model.
module tb_gbprocessor_gen;

   localparam int     W    = 8;
   localparam longint MASK = (longint'(1) << W) - 1;
   localparam int P_A = 0, P_B = 1, P_D = 3, P_F = 5;

   logic           clock = 1'b0;
   logic           reset, valid, busy, retire;
   logic [7:0]     instruction;
   logic [W-1:0]   data;
   logic [8*W-1:0] probe;

   int vectors = 0;
   int miscompares = 0;

   longint     m_reg [8];
   longint     mz, mn, mh, mc;
   bit         m_pending, m_retire;
   logic [7:0] m_op;

   always #5 clock = ~clock;

   gbprocessor_gen #(.DATA_W(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .instruction (instruction),
      .data        (data),
      .valid       (valid),
      .busy        (busy),
      .retire      (retire),
      .probe       (probe)
   );

   function automatic void model_reset();
      for (int i = 0; i < 6; i++) m_reg[i] = i + 1;
      m_reg[6] = 0;
      m_reg[7] = 0;
      mz = 0; mn = 0; mh = 0; mc = 0;
      m_pending = 0;
      m_retire  = 0;
   endfunction

   function automatic longint read_src(int idx);
      return (idx == 6) ? 0 : m_reg[idx];
   endfunction

   function automatic void model_alu(int o, longint b);
      longint a, r, cin;
      a   = m_reg[7];
      cin = (o == 1 || o == 3) ? mc : 0;
      mn  = 0;
      if (o <= 1) begin
         r  = a + b + cin;
         mh = (((a & 15) + (b & 15) + cin) > 15) ? 1 : 0;
         mc = (r > MASK) ? 1 : 0;
      end else if (o == 2 || o == 3 || o == 7) begin
         r  = a - b - cin;
         mh = (((a & 15) - (b & 15) - cin) < 0) ? 1 : 0;
         mc = (r < 0) ? 1 : 0;
         mn = 1;
      end else begin
         r  = (o == 4) ? (a & b) : (o == 5) ? (a ^ b) : (a | b);
         mh = (o == 4) ? 1 : 0;
         mc = 0;
      end
      r  = r & MASK;
      mz = (r == 0) ? 1 : 0;
      if (o != 7) m_reg[7] = r;
   endfunction

   function automatic void model_exec(logic [7:0] op, bit has_imm, longint imm);
      int     cls, d, s;
      longint v, r;
      cls = int'(op[7:6]);
      d   = int'(op[5:3]);
      s   = int'(op[2:0]);
      v   = has_imm ? imm : read_src(s);
      if (cls == 1) begin
         if (d != 6) m_reg[d] = v;
      end else if (cls == 2 || (cls == 3 && s == 6)) begin
         model_alu(d, v);
      end else if (cls == 0 && s == 6) begin
         if (d != 6) m_reg[d] = v;
      end
`ifdef GBP_INC_DEC_EN
      else if (cls == 0 && (s == 4 || s == 5) && d != 6) begin
         r = m_reg[d];
         if (s == 4) begin
            mh = (((r & 15) + 1) > 15) ? 1 : 0;
            r  = (r + 1) & MASK;
            mn = 0;
         end else begin
            mh = (((r & 15) - 1) < 0) ? 1 : 0;
            r  = (r - 1) & MASK;
            mn = 1;
         end
         mz = (r == 0) ? 1 : 0;
         m_reg[d] = r;
      end
`else
      r = 0;
`endif
   endfunction

   function automatic void model_step(bit v, logic [7:0] ins, longint d);
      m_retire = 0;
      if (!v) return;
      if (m_pending) begin
         model_exec(m_op, 1, d);
         m_pending = 0;
         m_retire  = 1;
      end else if ((ins[7:6] == 2'b00 || ins[7:6] == 2'b11) && ins[2:0] == 3'b110) begin
         m_pending = 1;
         m_op      = ins;
      end else begin
         model_exec(ins, 0, 0);
         m_retire = 1;
      end
   endfunction

   function automatic logic [8*W-1:0] expected_probe();
      longint f;
      f = ((mz << 3) | (mn << 2) | (mh << 1) | mc) << (W - 4);
      return {W'(m_reg[7]), W'(m_reg[0]), W'(m_reg[1]), W'(m_reg[2]),
              W'(m_reg[3]), W'(f), W'(m_reg[4]), W'(m_reg[5])};
   endfunction

   function automatic logic [W-1:0] reg_of(int slot);
      return probe[(7 - slot) * W +: W];
   endfunction

   task automatic check(string tag, logic [8*W-1:0] observed, logic [8*W-1:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic check_output();
      check("probe", probe, expected_probe());
      check("busy", {{(8*W-1){1'b0}}, busy}, {{(8*W-1){1'b0}}, m_pending});
      check("retire", {{(8*W-1){1'b0}}, retire}, {{(8*W-1){1'b0}}, m_retire});
   endtask

   task automatic apply_stimulus(bit v, logic [7:0] ins, logic [W-1:0] d);
      valid       = v;
      instruction = ins;
      data        = d;
      @(posedge clock);
      model_step(v, ins, longint'(d));
      #1;
      check_output();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      valid = 1'b0;
      @(posedge clock);
      model_reset();
      #1;
      reset = 1'b0;
      check_output();
   endtask

   initial begin
      reset       = 1'b1;
      valid       = 1'b0;
      instruction = '0;
      data        = '0;

      do_reset();
      check("rst_A", W'(reg_of(P_A)), 'h00);
      check("rst_B", W'(reg_of(P_B)), 'h01);

      apply_stimulus(1, 8'h80, 'h00);
      check("add_A", W'(reg_of(P_A)), 'h01);
      check("add_F", W'(reg_of(P_F)), 'h00);
      check("add_retire", W'(retire), 'h1);
      apply_stimulus(0, 8'h00, 'h00);
      check("idle_retire", W'(retire), 'h0);
      apply_stimulus(1, 8'h87, 'h00);
      check("addaa_A", W'(reg_of(P_A)), 'h02);

      apply_stimulus(1, 8'h3E, 'h00);
      check("ldi_busy", W'(busy), 'h1);
      apply_stimulus(1, 8'h80, 'hFF);
      check("ldi_A", W'(reg_of(P_A)), 'hFF);
      check("ldi_busy_clr", W'(busy), 'h0);
      apply_stimulus(1, 8'hC6, 'h00);
      apply_stimulus(1, 8'h00, 'h01);
      check("addi_A", W'(reg_of(P_A)), 'h00);
      check("addi_F", W'(reg_of(P_F)), 'hB0);

      do_reset();
      apply_stimulus(1, 8'h90, 'h00);
      check("sub_A", W'(reg_of(P_A)), 'hFF);
      check("sub_F", W'(reg_of(P_F)), 'h70);
      do_reset();
      apply_stimulus(1, 8'hB8, 'h00);
      check("cp_A", W'(reg_of(P_A)), 'h00);
      check("cp_F", W'(reg_of(P_F)), 'h70);

      do_reset();
      apply_stimulus(1, 8'h06, 'h00);
      for (int i = 0; i < 3; i++) apply_stimulus(0, 8'h80, 'hAA);
      check("hold_busy", W'(busy), 'h1);
      apply_stimulus(1, 8'h87, 'h55);
      check("hold_B", W'(reg_of(P_B)), 'h55);

      do_reset();
      apply_stimulus(1, 8'h06, 'h00);
      apply_stimulus(0, 8'h00, 'h00);
      do_reset();
      check("rstop_B", W'(reg_of(P_B)), 'h01);
      apply_stimulus(1, 8'h53, 'h00);
      check("ldde_D", W'(reg_of(P_D)), 'h04);
      check("ldde_F", W'(reg_of(P_F)), 'h00);

      do_reset();
      apply_stimulus(1, 8'h3E, 'h00);
      apply_stimulus(1, 8'h00, 'hF0);
      apply_stimulus(1, 8'hC6, 'h00);
      apply_stimulus(1, 8'h00, 'h20);
      check("carry_F", W'(reg_of(P_F)), 'h10);
      apply_stimulus(1, 8'h3E, 'h00);
      apply_stimulus(1, 8'h00, 'hFF);
      apply_stimulus(1, 8'h3C, 'h00);
      check("inc_retire", W'(retire), 'h1);
`ifdef GBP_INC_DEC_EN
      check("inc_A", W'(reg_of(P_A)), 'h00);
      check("inc_F", W'(reg_of(P_F)), 'hB0);
`else
      check("inc_A", W'(reg_of(P_A)), 'hFF);
      check("inc_F", W'(reg_of(P_F)), 'h10);
`endif

      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         else apply_stimulus($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), W'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
